data_bus_xcvr: RTL and testbench

DATA_BUS_XCVR -- requirements
Module: data_bus_xcvr

---
 rtl/dbx_pkg.sv | 19 +
 rtl/dbx_fifo.sv | 69 ++++++
 rtl/data_bus_xcvr.sv | 190 +++++++++++++++++++
 tb/tb_data_bus_xcvr.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbx_pkg.sv
// Shared types and constants for the data bus transceiver.
//   dbx_state_e  : transceiver FSM states
//   TurnMax      : largest supported bus-turnaround length in cycles
//   DefaultWidth : default CPU/internal data width
//   DefaultDepth : default write-buffer entry count
package dbx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTurn  = 2'd1,
    StDrive = 2'd2,
    StWcap  = 2'd3
  } dbx_state_e;

  localparam int unsigned TurnMax      = 3;
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 4;

endpackage

// File: rtl/dbx_fifo.sv
// Write buffer for the data bus transceiver: a DEPTH-entry circular FIFO.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : enqueue request and data
//   pop             : dequeue request (ignored while empty)
//   head            : oldest entry
//   full, empty     : occupancy flags derived from count
//   count           : number of stored entries
// A push while full is accepted only if a pop happens in the same cycle.
module dbx_fifo
  import dbx_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [WIDTH-1:0] push_data,
  input  logic            pop,
  output logic [WIDTH-1:0] head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  // Freeing the head slot this cycle makes room for the incoming entry.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_xcvr.sv
// CPU data bus transceiver. Turns CPU read strobes into an internal read
// request and drives the returned data back after a turnaround delay; captures
// CPU writes into a write buffer drained by an internal consumer.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   d_io              : CPU data bus, tri-stated unless driving a read
//   cs_n, rd_n, wr_n  : CPU strobes, active-low, synchronous to clk
//   rd_req / rd_data  : internal read request pulse / data one cycle later
//   wr_data/wr_valid  : write buffer head and non-empty flag
//   wr_ready          : consumer accepts the head
//   ovf, err          : sticky write-dropped and rd/wr-collision flags
//   wr_par            : even parity of wr_data (only with DBX_PARITY_EN)
// Build option: define DBX_PARITY_EN to store a parity bit per buffer entry.
module data_bus_xcvr
  import dbx_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned TURN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] d_io,
  input  logic             cs_n,
  input  logic             rd_n,
  input  logic             wr_n,
  output logic             rd_req,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic             ovf,
  output logic             err
`ifdef DBX_PARITY_EN
  ,
  output logic             wr_par
`endif
);

  // Turnaround lasts at least one cycle so rd_data can be captured.
  localparam int unsigned TurnLen = (TURN == 0) ? 1 : ((TURN > TurnMax) ? TurnMax : TURN);
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
`ifdef DBX_PARITY_EN
  localparam int unsigned EntryW  = WIDTH + 1;
`else
  localparam int unsigned EntryW  = WIDTH;
`endif

  dbx_state_e       state_q, state_d;
  logic [1:0]       turn_cnt_q, turn_cnt_d;
  logic [WIDTH-1:0] rd_latch_q, rd_latch_d;
  logic [WIDTH-1:0] wcap_q, wcap_d;
  logic             armed_q;
  logic             ovf_q;
  logic             err_q;

  logic             rd_active;
  logic             wr_active;
  logic             drive_en;
  logic             push;
  logic             err_set;
  logic             ovf_set;

  logic [EntryW-1:0] push_entry;
  logic [EntryW-1:0] head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic              unused_fifo_count;

  assign rd_active = !cs_n && !rd_n;
  assign wr_active = !cs_n && !wr_n;

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    rd_latch_d = rd_latch_q;
    wcap_d     = wcap_q;
    rd_req     = 1'b0;
    drive_en   = 1'b0;
    push       = 1'b0;
    err_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Read wins a collision; the write strobe is flagged and ignored.
        if (armed_q && rd_active) begin
          rd_req     = 1'b1;
          err_set    = !wr_n;
          turn_cnt_d = '0;
          state_d    = StTurn;
        end else if (armed_q && wr_active) begin
          wcap_d  = d_io;
          state_d = StWcap;
        end
      end
      StTurn: begin
        if (turn_cnt_q == '0) begin
          rd_latch_d = rd_data;
        end
        if (!rd_active) begin
          state_d = StIdle;
        end else if (turn_cnt_q == 2'(TurnLen - 1)) begin
          state_d = StDrive;
        end else begin
          turn_cnt_d = turn_cnt_q + 2'd1;
        end
      end
      StDrive: begin
        // Enable follows the strobes combinationally so the bus is released
        // in the same cycle the CPU ends the read.
        drive_en = rd_active;
        if (!rd_active) begin
          state_d = StIdle;
        end
      end
      StWcap: begin
        if (cs_n) begin
          state_d = StIdle;
        end else if (wr_n) begin
          push    = 1'b1;
          state_d = StIdle;
        end else begin
          wcap_d = d_io;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign d_io = drive_en ? rd_latch_q : {WIDTH{1'bz}};

  // Full implies non-empty, so wr_ready alone means a pop is happening.
  assign ovf_set = push && fifo_full && !wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      turn_cnt_q <= '0;
      rd_latch_q <= '0;
      wcap_q     <= '0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      rd_latch_q <= rd_latch_d;
      wcap_q     <= wcap_d;
      // Strobes held low through reset are ignored until seen inactive once.
      armed_q    <= armed_q | cs_n | (rd_n & wr_n);
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef DBX_PARITY_EN
  assign push_entry = {^wcap_q, wcap_q};
  assign wr_par     = head_entry[WIDTH];
`else
  assign push_entry = wcap_q;
`endif

  dbx_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (wr_ready),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  assign wr_data  = head_entry[WIDTH-1:0];
  assign wr_valid = !fifo_empty;
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_bus_xcvr.sv
// Self-checking bench for data_bus_xcvr (WIDTH=8, DEPTH=4, TURN=1).
// The bus has a pull-up, so a released bus reads as all ones; read data
// values are chosen never to be all ones.
module tb_data_bus_xcvr;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int Rel = 255;  // released bus as seen through the pull-up
  localparam int Skp = -1;   // bench is driving, bus not checked

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tri1 [W-1:0] d_bus;
  logic [W-1:0] tb_d;
  logic         tb_oe;
  assign d_bus = tb_oe ? tb_d : {W{1'bz}};

  logic         cs_n, rd_n, wr_n, rd_req, wr_valid, wr_ready, ovf, err;
  logic [W-1:0] rd_data, wr_data;
`ifdef DBX_PARITY_EN
  logic         wr_par;
`endif

  data_bus_xcvr #(
    .WIDTH (W),
    .DEPTH (D),
    .TURN  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_io     (d_bus),
    .cs_n     (cs_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .ovf      (ovf),
    .err      (err)
`ifdef DBX_PARITY_EN
    ,
    .wr_par   (wr_par)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: buffer contents as a queue plus the sticky flags.
  logic [W-1:0] q[$];
  bit ovf_m, err_m, pend_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    ovf_m    = 1'b0;
    err_m    = 1'b0;
    pend_err = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit push, input logic [W-1:0] pd, input int bus_exp,
                       input logic rdreq_exp);
    bit pop;
    @(negedge clk);
    chk("wr_valid", wr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("wr_data", wr_data, q[0]);
`ifdef DBX_PARITY_EN
      chk("wr_par", wr_par, ^q[0]);
`endif
    end
    chk("ovf", ovf, ovf_m);
    chk("err", err, err_m);
    chk("rd_req", rd_req, rdreq_exp);
    if (bus_exp >= 0) chk("d_io", d_bus, bus_exp);
    @(posedge clk);
    pop = wr_ready && q.size() != 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < D) q.push_back(pd);
      else ovf_m = 1'b1;
    end
    err_m    = err_m | pend_err;
    pend_err = 1'b0;
    #1;
  endtask

  // Write: n cycles with wr_n low (val on the last), then wr_n high pushes.
  task automatic do_write(input logic [W-1:0] val, input int n, input bit pop_at_push);
    for (int i = 0; i < n; i++) begin
      cs_n  = 1'b0;
      wr_n  = 1'b0;
      tb_oe = 1'b1;
      tb_d  = (i == n - 1) ? val : W'($urandom);
      cycle(1'b0, '0, Skp, 1'b0);
    end
    wr_n  = 1'b1;
    tb_oe = 1'b0;
    if (pop_at_push) wr_ready = 1'b1;
    cycle(1'b1, val, Rel, 1'b0);
    wr_ready = 1'b0;
    cs_n     = 1'b1;
  endtask

  // Read: n>=2 cycles with rd_n low; rd_data is only valid the cycle after rd_req.
  task automatic do_read(input logic [W-1:0] val, input int n, input bit with_wr);
    cs_n    = 1'b0;
    rd_n    = 1'b0;
    rd_data = ~val;
    if (with_wr) begin
      wr_n     = 1'b0;
      pend_err = 1'b1;
    end
    cycle(1'b0, '0, Rel, 1'b1);
    wr_n    = 1'b1;
    rd_data = val;
    cycle(1'b0, '0, Rel, 1'b0);
    rd_data = ~val;
    for (int i = 2; i < n; i++) cycle(1'b0, '0, val, 1'b0);
    rd_n = 1'b1;
    cycle(1'b0, '0, Rel, 1'b0);
    cs_n = 1'b1;
  endtask

  task automatic drain();
    wr_ready = 1'b1;
    for (int i = 0; i < D + 1 && q.size() > 0; i++) cycle(1'b0, '0, Rel, 1'b0);
    wr_ready = 1'b0;
    cycle(1'b0, '0, Rel, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; wr_ready = 1'b0;
    rd_data = '0; tb_oe = 1'b0; tb_d = '0; rst_n = 1'b0;
    reset_model();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_bus", d_bus, Rel);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, Rel, 1'b0);
    cycle(1'b0, '0, Rel, 1'b0);

    // Single write of 0xA5, visible one cycle after wr_n rises.
    do_write(8'hA5, 3, 1'b0);
    cycle(1'b0, '0, Rel, 1'b0);
    chk("a5_head", wr_data, 8'hA5);
    drain();

    // Directed read of 0x3C, then randomized reads.
    do_read(8'h3C, 4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_read(W'($urandom_range(0, 254)), int'($urandom_range(2, 5)), 1'b0);
      cycle(1'b0, '0, Rel, 1'b0);
    end

    // Read/write collision: err set, read served, nothing pushed.
    do_read(8'h5A, 3, 1'b1);
    chk("collide_err", err, 1'b1);
    chk("collide_no_push", wr_valid, 1'b0);

    // Write aborted by cs_n rising first.
    cs_n = 1'b0; wr_n = 1'b0; tb_oe = 1'b1; tb_d = 8'h11;
    cycle(1'b0, '0, Skp, 1'b0);
    cycle(1'b0, '0, Skp, 1'b0);
    cs_n = 1'b1;
    cycle(1'b0, '0, Skp, 1'b0);
    wr_n = 1'b1; tb_oe = 1'b0;
    cycle(1'b0, '0, Rel, 1'b0);
    cycle(1'b0, '0, Rel, 1'b0);

    // Read aborted in turnaround, then a fresh read must start from idle.
    cs_n = 1'b0; rd_n = 1'b0; rd_data = 8'h00;
    cycle(1'b0, '0, Rel, 1'b1);
    rd_n = 1'b1; rd_data = 8'h42;
    cycle(1'b0, '0, Rel, 1'b0);
    rd_n = 1'b0; rd_data = 8'h00;
    cycle(1'b0, '0, Rel, 1'b1);
    rd_data = 8'h66;
    cycle(1'b0, '0, Rel, 1'b0);
    rd_data = 8'h00;
    cycle(1'b0, '0, 8'h66, 1'b0);
    rd_n = 1'b1;
    cycle(1'b0, '0, Rel, 1'b0);
    cs_n = 1'b1;

    // Overflow: five writes into a four-entry buffer.
    for (int i = 1; i <= 5; i++) begin
      do_write(W'(i), 2, 1'b0);
      cycle(1'b0, '0, Rel, 1'b0);
    end
    chk("ovf_after_5", ovf, 1'b1);
    drain();
    do_write(8'h99, 1, 1'b0);

    // Reset during a driven read releases the bus immediately.
    cs_n = 1'b0; rd_n = 1'b0; rd_data = 8'h00;
    cycle(1'b0, '0, Rel, 1'b1);
    rd_data = 8'h81;
    cycle(1'b0, '0, Rel, 1'b0);
    #1;
    chk("drive_pre_rst", d_bus, 8'h81);
    #1;
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("rst_mid_bus", d_bus, Rel);
    chk("rst_mid_rd_req", rd_req, 1'b0);
    chk("rst_mid_wr_valid", wr_valid, 1'b0);
    chk("rst_mid_ovf", ovf, 1'b0);
    chk("rst_mid_err", err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Strobes held low across reset are ignored until seen high.
    cycle(1'b0, '0, Rel, 1'b0);
    cycle(1'b0, '0, Rel, 1'b0);
    rd_n = 1'b1;
    cycle(1'b0, '0, Rel, 1'b0);
    do_read(8'h24, 3, 1'b0);

    // Full buffer with simultaneous push and pop: no overflow, 0x06 last.
    for (int i = 0; i < D; i++) do_write(W'($urandom), 1, 1'b0);
    do_write(8'h06, 2, 1'b1);
    cycle(1'b0, '0, Rel, 1'b0);
    chk("full_pp_ovf", ovf, 1'b0);
    drain();

`ifdef DBX_PARITY_EN
    do_write(8'h07, 2, 1'b0);
    cycle(1'b0, '0, Rel, 1'b0);
    chk("par_07", wr_par, 1'b1);
    drain();
`endif

    // Randomized mix of reads and writes with a random consumer.
    for (int i = 0; i < 24; i++) begin
      wr_ready = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(W'($urandom), int'($urandom_range(1, 3)), 1'b0);
      end else begin
        v = W'($urandom_range(0, 254));
        do_read(v, int'($urandom_range(2, 4)), 1'b0);
      end
      cycle(1'b0, '0, Rel, 1'b0);
    end
    wr_ready = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
